charbuf_port_arbiter: RTL and testbench

Sequences and shares port A of the VGA character-buffer block RAM (4096 × 8, one-cycle unregistered read latency) between two requesters: the processor I/O bus, which issues single-byte reads and writes, and a hardware fill engine that writes a constant byte over an address range (clear screen, clear line). It sits between the I/O-bus decode logic and the BRAM wrapper. Port B stays owned by the VGA scan-out logic and is outside this block.

---
 rtl/charbuf_pkg.sv | 24 ++
 rtl/charbuf_fill_seq.sv | 65 ++++++
 rtl/charbuf_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_charbuf_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/charbuf_pkg.sv
// rtl/charbuf_pkg.sv - shared widths and state/grant types for the character-buffer port-A arbiter
package charbuf_pkg;

    localparam int CHARBUF_ADDR_W = 12;
    localparam int CHARBUF_DATA_W = 8;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_PEND = 2'd1,
        CPU_RD1  = 2'd2,
        CPU_RD2  = 2'd3
    } cpu_state_t;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_FILL = 1'b1
    } grant_t;

endpackage

// File: rtl/charbuf_fill_seq.sv
// rtl/charbuf_fill_seq.sv - fill engine: walks an address range issuing one constant-byte write per grant
module charbuf_fill_seq
    import charbuf_pkg::*;
#(
    parameter int ADDR_W = CHARBUF_ADDR_W,
    parameter int DATA_W = CHARBUF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] value,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    fill_state_t       state;
    logic [ADDR_W:0]   remaining;

    assign req  = (state == FILL_RUN);
    assign busy = (state == FILL_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL_IDLE;
            addr      <= '0;
            data      <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                FILL_IDLE: begin
                    if (start) begin
                        addr      <= base;
                        data      <= value;
                        remaining <= len;
                        // A zero-length fill still reports completion, without ever going busy
                        if (len == '0)
                            done <= 1'b1;
                        else
                            state <= FILL_RUN;
                    end
                end
                FILL_RUN: begin
                    if (grant) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state <= FILL_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= FILL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/charbuf_port_arbiter.sv
// rtl/charbuf_port_arbiter.sv - shares BRAM port A between CPU byte accesses and the fill engine
module charbuf_port_arbiter
    import charbuf_pkg::*;
#(
    parameter int ADDR_W = CHARBUF_ADDR_W,
    parameter int DATA_W = CHARBUF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_strobe,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    cpu_state_t        cpu_state;
    grant_t            last_grant;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;

    logic              cpu_req;
    logic              fill_req;
    logic              gnt_cpu;
    logic              gnt_fill;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    charbuf_fill_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill_seq (
        .clk   (clk),
        .rst   (rst),
        .start (fill_start),
        .base  (fill_base),
        .len   (fill_len),
        .value (fill_value),
        .grant (gnt_fill),
        .req   (fill_req),
        .addr  (fill_addr),
        .data  (fill_data),
        .busy  (fill_busy),
        .done  (fill_done)
    );

    assign cpu_busy = (cpu_state != CPU_IDLE);

    // A strobe in idle competes in its own cycle, so it is taken straight from the ports
    always_comb begin
        cpu_req  = ((cpu_state == CPU_IDLE) && cpu_strobe) || (cpu_state == CPU_PEND);
        gnt_cpu  = cpu_req  && (!fill_req || (last_grant == GNT_FILL));
        gnt_fill = fill_req && (!cpu_req  || (last_grant == GNT_CPU));
        if (cpu_state == CPU_IDLE) begin
            cmd_we    = cpu_we;
            cmd_addr  = cpu_addr;
            cmd_wdata = cpu_wdata;
        end else begin
            cmd_we    = pend_we;
            cmd_addr  = pend_addr;
            cmd_wdata = pend_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_state  <= CPU_IDLE;
            last_grant <= GNT_FILL;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            bram_addr  <= '0;
            bram_we    <= 1'b0;
            bram_din   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            bram_we <= 1'b0;

            if (gnt_cpu) begin
                bram_addr  <= cmd_addr;
                bram_we    <= cmd_we;
                bram_din   <= cmd_wdata;
                last_grant <= GNT_CPU;
            end else if (gnt_fill) begin
                bram_addr  <= fill_addr;
                bram_we    <= 1'b1;
                bram_din   <= fill_data;
                last_grant <= GNT_FILL;
            end

            case (cpu_state)
                CPU_IDLE: begin
                    if (cpu_strobe) begin
                        pend_we    <= cpu_we;
                        pend_addr  <= cpu_addr;
                        pend_wdata <= cpu_wdata;
                        if (!gnt_cpu)
                            cpu_state <= CPU_PEND;
                        else if (cpu_we)
                            cpu_ack <= 1'b1;
                        else
                            cpu_state <= CPU_RD1;
                    end
                end
                CPU_PEND: begin
                    if (gnt_cpu) begin
                        if (pend_we) begin
                            cpu_ack   <= 1'b1;
                            cpu_state <= CPU_IDLE;
                        end else begin
                            cpu_state <= CPU_RD1;
                        end
                    end
                end
                // RD1 covers the BRAM access; data is captured as RD2 retires
                CPU_RD1: cpu_state <= CPU_RD2;
                CPU_RD2: begin
                    cpu_rdata <= bram_dout;
                    cpu_ack   <= 1'b1;
                    cpu_state <= CPU_IDLE;
                end
                default: cpu_state <= CPU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_charbuf_port_arbiter.sv
// tb/tb_charbuf_port_arbiter.sv - directed self-checking bench for charbuf_port_arbiter
module tb_charbuf_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_strobe;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        fill_start;
    logic [11:0] fill_base;
    logic [12:0] fill_len;
    logic [7:0]  fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic [11:0] bram_addr;
    logic        bram_we;
    logic [7:0]  bram_din;
    logic [7:0]  bram_dout;

    logic [7:0]  mem [0:4095];

    int checks   = 0;
    int failures = 0;

    charbuf_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_strobe (cpu_strobe),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_busy   (cpu_busy),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we)
            mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] exp_wrap [4];
        int bad;
        int strobes;
        int acks;
        int cpu_wr;
        int fill_wr;
        int alt_err;
        int prev_kind;
        int kind;
        int busy_cycles;
        int seen_done;

        exp_wrap[0] = 12'hFFE;
        exp_wrap[1] = 12'hFFF;
        exp_wrap[2] = 12'h000;
        exp_wrap[3] = 12'h001;

        rst        = 1'b1;
        cpu_strobe = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_value = '0;
        bram_dout  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_bram_we",   32'(bram_we),   32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_din",  32'(bram_din),  32'd0);
        chk("rst_cpu_busy",  32'(cpu_busy),  32'd0);
        chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);

        // CPU write 0x41 -> 0x123
        cpu_strobe = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h41;
        tick();
        cpu_strobe = 1'b0;
        chk("wr_bram_we",   32'(bram_we),   32'd1);
        chk("wr_bram_addr", 32'(bram_addr), 32'h123);
        chk("wr_bram_din",  32'(bram_din),  32'h41);
        chk("wr_ack",       32'(cpu_ack),   32'd1);
        chk("wr_busy",      32'(cpu_busy),  32'd0);
        tick();
        chk("wr_ack_pulse", 32'(cpu_ack),   32'd0);
        chk("wr_we_pulse",  32'(bram_we),   32'd0);

        // CPU read 0x123
        cpu_strobe = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123; cpu_wdata = 8'h00;
        tick();
        cpu_strobe = 1'b0;
        chk("rd_s1_addr", 32'(bram_addr), 32'h123);
        chk("rd_s1_we",   32'(bram_we),   32'd0);
        chk("rd_s1_busy", 32'(cpu_busy),  32'd1);
        chk("rd_s1_ack",  32'(cpu_ack),   32'd0);
        tick();
        chk("rd_s2_ack",  32'(cpu_ack),   32'd0);
        chk("rd_s2_busy", 32'(cpu_busy),  32'd1);
        tick();
        chk("rd_s3_ack",   32'(cpu_ack),   32'd1);
        chk("rd_s3_rdata", 32'(cpu_rdata), 32'h41);
        chk("rd_s3_busy",  32'(cpu_busy),  32'd0);
        tick();
        chk("rd_ack_pulse", 32'(cpu_ack),   32'd0);
        chk("rd_rdata_hold", 32'(cpu_rdata), 32'h41);

        // fill 0x000, len 2400, value 0x20
        fill_start = 1'b1; fill_base = 12'h000; fill_len = 13'd2400; fill_value = 8'h20;
        chk("fill_busy_F", 32'(fill_busy), 32'd0);
        tick();
        fill_start = 1'b0;
        chk("fill_busy_F1", 32'(fill_busy), 32'd1);
        chk("fill_we_F1",   32'(bram_we),   32'd0);
        bad = 0;
        for (int i = 0; i < 2400; i++) begin
            tick();
            if (!(bram_we === 1'b1 && bram_addr === i[11:0] && bram_din === 8'h20)) bad++;
            if (fill_done !== (i == 2399)) bad++;
            if (fill_busy !== (i < 2399)) bad++;
        end
        chk("fill2400_stream_errors", 32'(bad), 32'd0);
        chk("fill2400_done",          32'(fill_done), 32'd1);
        chk("fill2400_busy_after",    32'(fill_busy), 32'd0);
        tick();
        chk("fill2400_done_pulse", 32'(fill_done), 32'd0);
        chk("fill2400_we_after",   32'(bram_we),   32'd0);
        chk("fill2400_mem_last",   32'(mem[12'd2399]), 32'h20);

        // wrapping fill 0xFFE, len 4
        fill_start = 1'b1; fill_base = 12'hFFE; fill_len = 13'd4; fill_value = 8'h55;
        tick();
        fill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("wrap_we_addr%0d", k), 32'({bram_we, bram_addr}), 32'({1'b1, exp_wrap[k]}));
        end
        chk("wrap_din",  32'(bram_din),  32'h55);
        chk("wrap_done", 32'(fill_done), 32'd1);
        tick();
        chk("wrap_we_after", 32'(bram_we), 32'd0);

        // zero-length fill
        fill_start = 1'b1; fill_base = 12'h500; fill_len = 13'd0; fill_value = 8'h99;
        tick();
        fill_start = 1'b0;
        chk("len0_done", 32'(fill_done), 32'd1);
        chk("len0_busy", 32'(fill_busy), 32'd0);
        chk("len0_we",   32'(bram_we),   32'd0);
        tick();
        chk("len0_done_pulse", 32'(fill_done), 32'd0);
        chk("len0_busy_after", 32'(fill_busy), 32'd0);
        chk("len0_we_after",   32'(bram_we),   32'd0);

        // contention: CPU writes strobed whenever allowed during an 8-byte fill
        fill_start = 1'b1; fill_base = 12'h200; fill_len = 13'd8; fill_value = 8'h66;
        tick();
        fill_start = 1'b0;
        strobes = 0; acks = 0; cpu_wr = 0; fill_wr = 0; alt_err = 0;
        prev_kind = -1; busy_cycles = 0; seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (fill_busy) busy_cycles++;
            if (fill_done) seen_done++;
            if (cpu_ack) acks++;
            if (bram_we) begin
                kind = (bram_addr >= 12'h800) ? 1 : 0;
                if (kind == 1) cpu_wr++; else fill_wr++;
                if (kind == prev_kind) alt_err++;
                prev_kind = kind;
            end
            if (fill_busy && !cpu_busy) begin
                strobes++;
                cpu_strobe = 1'b1; cpu_we = 1'b1;
                cpu_addr = 12'h800 + 12'(strobes); cpu_wdata = 8'(strobes);
            end
            tick();
            cpu_strobe = 1'b0;
        end
        chk("cont_strobes",     32'(strobes),     32'd9);
        chk("cont_acks",        32'(acks),        32'd9);
        chk("cont_cpu_writes",  32'(cpu_wr),      32'd9);
        chk("cont_fill_writes", 32'(fill_wr),     32'd8);
        chk("cont_alternation", 32'(alt_err),     32'd0);
        chk("cont_busy_cycles", 32'(busy_cycles), 32'd16);
        chk("cont_done_count",  32'(seen_done),   32'd1);
        chk("cont_mem_fill",    32'(mem[12'h207]), 32'h66);
        chk("cont_mem_cpu",     32'(mem[12'h809]), 32'h09);

        // reset mid-fill with a read in RD1
        fill_start = 1'b1; fill_base = 12'h300; fill_len = 13'd20; fill_value = 8'h77;
        tick();
        fill_start = 1'b0;
        cpu_strobe = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        tick();
        cpu_strobe = 1'b0;
        chk("mid_fill_won", 32'({bram_we, bram_addr}), 32'({1'b1, 12'h300}));
        chk("mid_cpu_pend", 32'(cpu_busy), 32'd1);
        tick();
        chk("mid_rd1_addr", 32'({bram_we, bram_addr}), 32'({1'b0, 12'h123}));
        rst = 1'b1;
        tick();
        chk("mid_rst_outputs",
            32'({bram_we, bram_addr, bram_din, cpu_busy, cpu_ack, fill_busy, fill_done}), 32'd0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cpu_ack !== 1'b0 || fill_done !== 1'b0 || bram_we !== 1'b0 ||
                cpu_busy !== 1'b0 || fill_busy !== 1'b0) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);

        cpu_strobe = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'h5A;
        tick();
        cpu_strobe = 1'b0;
        chk("post_rst_wr", 32'({cpu_ack, bram_we, bram_addr, bram_din}), 32'({1'b1, 1'b1, 12'h010, 8'h5A}));
        fill_start = 1'b1; fill_base = 12'h020; fill_len = 13'd1; fill_value = 8'h33;
        tick();
        fill_start = 1'b0;
        chk("post_rst_fill_busy", 32'(fill_busy), 32'd1);
        tick();
        chk("post_rst_fill_wr", 32'({fill_done, bram_we, bram_addr, bram_din}), 32'({1'b1, 1'b1, 12'h020, 8'h33}));
        tick();
        chk("post_rst_fill_end", 32'({fill_done, fill_busy}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
